uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized RXD, OSR-times oversampling with mid-bit sampling,
// sticky ready/overrun flags and a per-frame framing-error flag.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s low on a sample tick
// ST_START | qualifying the start bit at its midpoint
// ST_DATA  | sampling DBITS data bits, LSB first, once per bit period
// ST_STOP  | sampling the stop bit, then reporting the frame
module uart_rx #(
   parameter int OSR   = 16,
   parameter int DBITS = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             BDSAM,
   input  logic             RXD,
   output logic [DBITS-1:0] DATA,
   output logic             DVALID,
   output logic             RDY,
   input  logic             RD_ACK,
   output logic             OVR,
   output logic             FERR,
   output logic             BUSY
);

   localparam int TW = $clog2(OSR);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [TW-1:0] TICK_HALF = TW'(OSR / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OSR - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DBITS - 1);

   logic             sync1_q, sync1_d;
   logic             rx_s_q, rx_s_d;
   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic [2:0]       bit_q, bit_d;
   logic [DBITS-1:0] shift_q, shift_d;
   logic [DBITS-1:0] data_q, data_d;
   logic             dvalid_q, dvalid_d;
   logic             rdy_q, rdy_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;
   logic             stop_good, stop_bad;

   always_comb begin
      sync1_d   = RXD;
      rx_s_d    = sync1_q;
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      stop_good = 1'b0;
      stop_bad  = 1'b0;

      if (BDSAM) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx_s_q) begin
                  state_d = ST_START;
                  tick_d  = '0;
               end
            end
            ST_START: begin
               if (tick_q == TICK_HALF) begin
                  tick_d = '0;
                  if (rx_s_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_DATA;
                     bit_d   = '0;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (tick_q == TICK_LAST) begin
                  shift_d = {rx_s_q, shift_q[DBITS-1:1]};
                  tick_d  = '0;
                  if (bit_q == BIT_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            ST_STOP: begin
               if (tick_q == TICK_LAST) begin
                  state_d   = ST_IDLE;
                  tick_d    = '0;
                  stop_good = rx_s_q;
                  stop_bad  = !rx_s_q;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // A good frame that lands together with RD_ACK leaves RDY set and OVR clear.
   always_comb begin
      data_d   = data_q;
      dvalid_d = stop_good;
      rdy_d    = rdy_q;
      ovr_d    = ovr_q;
      ferr_d   = ferr_q;

      if (RD_ACK) begin
         rdy_d = 1'b0;
         ovr_d = 1'b0;
      end
      if (stop_good) begin
         data_d = shift_q;
         rdy_d  = 1'b1;
         ferr_d = 1'b0;
         if (rdy_q && !RD_ACK) begin
            ovr_d = 1'b1;
         end
      end
      if (stop_bad) begin
         ferr_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q  <= 1'b1;
         rx_s_q   <= 1'b1;
         state_q  <= ST_IDLE;
         tick_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         dvalid_q <= 1'b0;
         rdy_q    <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         rx_s_q   <= rx_s_d;
         state_q  <= state_d;
         tick_q   <= tick_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         dvalid_q <= dvalid_d;
         rdy_q    <= rdy_d;
         ovr_q    <= ovr_d;
         ferr_q   <= ferr_d;
      end
   end

   assign DATA   = data_q;
   assign DVALID = dvalid_q;
   assign RDY    = rdy_q;
   assign OVR    = ovr_q;
   assign FERR   = ferr_q;
   assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised onto RXD, expected bytes and
// flag states come from a frame-level model, and a monitor checks every DVALID.
module tb_uart_rx;
   localparam int OSR   = 16;
   localparam int DBITS = 8;

   logic       CLK = 1'b0;
   logic       RST, BDSAM, RXD, RD_ACK;
   logic [7:0] DATA;
   logic       DVALID, RDY, OVR, FERR, BUSY;

   uart_rx #(.OSR(OSR), .DBITS(DBITS)) dut (
      .CLK(CLK), .RST(RST), .BDSAM(BDSAM), .RXD(RXD), .DATA(DATA), .DVALID(DVALID),
      .RDY(RDY), .RD_ACK(RD_ACK), .OVR(OVR), .FERR(FERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   int checks = 0, errors = 0;
   int div = 1, ph = 0;
   int dv_seen = 0, dv_exp = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_e;
   logic [7:0] m_data;
   bit m_rdy, m_ovr, m_ferr;

   initial begin
      BDSAM = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         ph    = (ph + 1) % div;
         BDSAM = (ph == 0);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   always @(negedge CLK) begin
      if (DVALID === 1'b1) begin
         dv_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL dvalid_unexpected got DATA=%0h, no frame expected", DATA);
         end else begin
            mon_e = exp_q.pop_front();
            if (DATA !== mon_e) begin
               errors++;
               $display("FAIL dvalid_data got %0h expected %0h", DATA, mon_e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_bit(input logic v, input int n);
      RXD = v;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Frame-level model: a good stop bit delivers the byte, a bad one only raises FERR.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit ack_at_end);
      int bt;
      bt = OSR * div;
      if (stop_ok) begin
         exp_q.push_back(d);
         dv_exp++;
         m_ovr  = ack_at_end ? 1'b0 : (m_ovr | m_rdy);
         m_rdy  = 1'b1;
         m_data = d;
         m_ferr = 1'b0;
      end else begin
         m_ferr = 1'b1;
      end
      @(posedge CLK);
      #1;
      drive_bit(1'b0, bt);
      for (int i = 0; i < DBITS; i++) drive_bit(d[i], bt);
      if (stop_ok) drive_bit(1'b1, bt);
      else         drive_bit(1'b0, bt * 3 / 4);
      drive_bit(1'b1, bt * 2);
   endtask

   task automatic ack_pulse();
      @(posedge CLK);
      #1 RD_ACK = 1'b1;
      @(posedge CLK);
      #1 RD_ACK = 1'b0;
      m_rdy = 1'b0;
      m_ovr = 1'b0;
   endtask

   task automatic check_state(input string tag);
      @(negedge CLK);
      chk({tag, "_data"}, DATA, m_data);
      chk({tag, "_rdy"},  RDY,  m_rdy);
      chk({tag, "_ovr"},  OVR,  m_ovr);
      chk({tag, "_ferr"}, FERR, m_ferr);
      chk({tag, "_busy"}, BUSY, 1'b0);
   endtask

   initial begin
      bit got_dv;
      RXD = 1'b1; RD_ACK = 1'b0; RST = 1'b1;
      m_data = '0; m_rdy = 0; m_ovr = 0; m_ferr = 0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_data", DATA, 8'h00);
      chk("rst_dvalid", DVALID, 1'b0);
      chk("rst_rdy", RDY, 1'b0);
      chk("rst_ovr", OVR, 1'b0);
      chk("rst_ferr", FERR, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (4) @(posedge CLK);

      send_frame(8'hA5, 1'b1, 1'b0);
      check_state("a5");
      chk("a5_data_const", DATA, 8'hA5);
      chk("a5_one_pulse", dv_seen, 1);

      // False start: 4 ticks low, FSM must give up exactly at its half-bit check.
      @(posedge CLK);
      #1 RXD = 1'b0;
      repeat (4) @(posedge CLK);
      #1 RXD = 1'b1;
      repeat (6) @(posedge CLK);
      @(negedge CLK);
      chk("false_start_busy_tick6", BUSY, 1'b1);
      @(posedge CLK);
      @(negedge CLK);
      chk("false_start_idle_tick7", BUSY, 1'b0);
      repeat (40) @(posedge CLK);
      check_state("false_start");

      send_frame(8'h81, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0);
      check_state("ferr");
      chk("ferr_flag", FERR, 1'b1);
      chk("ferr_keeps_data", DATA, 8'h81);
      ack_pulse();

      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      check_state("ovr");
      chk("ovr_set", OVR, 1'b1);
      chk("ovr_data", DATA, 8'h22);
      ack_pulse();
      check_state("ovr_ack");

      // RD_ACK held across the completion cycle of the second frame.
      send_frame(8'h33, 1'b1, 1'b0);
      got_dv = 1'b0;
      fork
         send_frame(8'h44, 1'b1, 1'b1);
         begin
            repeat (9 * OSR * div + 2) @(posedge CLK);
            #1 RD_ACK = 1'b1;
            for (int i = 0; i < 40 && !got_dv; i++) begin
               @(negedge CLK);
               if (DVALID === 1'b1) got_dv = 1'b1;
            end
            RD_ACK = 1'b0;
            chk("ack_same_cycle_dvalid_seen", got_dv, 1'b1);
         end
      join
      check_state("ack_same");
      chk("ack_same_rdy", RDY, 1'b1);
      chk("ack_same_ovr", OVR, 1'b0);

      // Reset in the middle of data bit 4.
      @(posedge CLK);
      #1;
      drive_bit(1'b0, OSR);
      for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i), OSR);
      RXD = 1'b1;
      repeat (OSR / 2) @(posedge CLK);
      @(negedge CLK);
      chk("midframe_busy", BUSY, 1'b1);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      chk("midrst_data", DATA, 8'h00);
      chk("midrst_dvalid", DVALID, 1'b0);
      chk("midrst_rdy", RDY, 1'b0);
      chk("midrst_ovr", OVR, 1'b0);
      chk("midrst_ferr", FERR, 1'b0);
      chk("midrst_busy", BUSY, 1'b0);
      RST = 1'b0;
      m_data = '0; m_rdy = 0; m_ovr = 0; m_ferr = 0;
      repeat (3 * OSR) @(posedge CLK);
      send_frame(8'h5A, 1'b1, 1'b0);
      check_state("after_rst");
      chk("after_rst_data_const", DATA, 8'h5A);

      // Randomized frames with gated BDSAM rates and random acknowledges.
      for (int n = 0; n < 20; n++) begin
         logic [7:0] d;
         bit ok;
         div = 1 << $urandom_range(0, 2);
         d   = 8'($urandom);
         ok  = ($urandom_range(0, 4) != 0);
         send_frame(d, ok, 1'b0);
         check_state("rand");
         if ($urandom_range(0, 2) == 0) ack_pulse();
      end

      repeat (20) @(posedge CLK);
      chk("dvalid_count", dv_seen, dv_exp);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
